// File: rtl/sum_accumulator_pkg.sv
// Shared definitions for the frame accumulator: FSM encoding and beat width.
package sum_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Width of one {cout, sum} beat from the 16-bit adder.
  localparam int BEAT_W = 17;

endpackage

// File: rtl/sum_accumulator.sv
// Accumulates FRAME_LEN {cout, sum} beats into an ACC_W-bit total with a
// sticky overflow flag; ready/valid on the input beat and the frame result.
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int ACC_W     = 24,
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_sum,
  input  logic             in_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; ready is decoded from state only and never depends on valid.

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] out_acc_q, out_acc_d;
  logic             out_ovf_q, out_ovf_d;

  logic [ACC_W-1:0] beat_val;
  logic [ACC_W:0]   sum_w;
  logic             last_beat;

  assign beat_val  = ACC_W'({in_cout, in_sum});
  assign sum_w     = {1'b0, acc_q} + {1'b0, beat_val};
  assign last_beat = (count_q == CNT_W'(FRAME_LEN - 1));

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    out_acc_d = out_acc_q;
    out_ovf_d = out_ovf_q;

    if (abort) begin
      // Result registers keep the last completed frame across an abort.
      state_d = ST_IDLE;
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
          end
        end
        ST_ACCUM: begin
          if (in_valid) begin
            acc_d = sum_w[ACC_W-1:0];
            ovf_d = ovf_q | sum_w[ACC_W];
            if (last_beat) begin
              state_d   = ST_DONE;
              count_d   = '0;
              out_acc_d = sum_w[ACC_W-1:0];
              out_ovf_d = ovf_q | sum_w[ACC_W];
            end else begin
              count_d = count_q + CNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            if (start) begin
              // Back-to-back frames skip the IDLE bubble.
              state_d = ST_ACCUM;
              acc_d   = '0;
              count_d = '0;
              ovf_d   = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      out_acc_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      out_acc_q <= out_acc_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign count     = count_q;
  assign out_acc   = out_acc_q;
  assign out_ovf   = out_ovf_q;

endmodule
